memory_controller: RTL and testbench
====================================

MEMORY_CONTROLLER -- requirements
Module: memory_controller

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, with ports named as in the codebase:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous active-low reset (0 = reset).
REQ-002 The remaining ports SHALL be:
- ENABLE  in  1  transaction request.
- Ctrl  in  2  operation: 00 idle, 01 strided (vertical) burst, 10 single read, 11 unit-stride (horizontal) burst.
- IndexCtrl  in  2  burst word count: 00→1, 01→2, 10→3, 11→3.
- ADDRESS  in  48  [15:0] base word address, [31:16] vertical stride, [47:32] reserved/ignored.
- ReadMem  in  16  memory read data; registered memory, valid one cycle after AddressMem is sampled.
- AddressMem  out  32  registered word address to memory, zero-extended.
- HANDSHAKE  out  1  result valid / transaction done.
- READ  out  48  packed result; word i in bits [16i+15:16i].

Function
REQ-003 States SHALL be IDLE, REQ, WAIT, CAP, DONE.
REQ-004 IDLE → REQ SHALL occur when ENABLE=1 and Ctrl≠00; otherwise the block stays in IDLE.
REQ-005 On leaving IDLE, the block SHALL latch Ctrl, IndexCtrl, base, and stride, clear READ to 0, and clear word index i to 0. ADDRESS/Ctrl changes after this edge (including X) SHALL have no effect.
REQ-006 The number of words N SHALL be 1 for Ctrl=10; for Ctrl=01/11, N SHALL be taken from IndexCtrl per REQ-002.
REQ-007 In REQ, AddressMem SHALL be base + i*step (32-bit, modulo 2^32). step = stride for Ctrl=01, 1 for Ctrl=11, and 0 for Ctrl=10.
REQ-008 REQ SHALL go to WAIT, then WAIT to CAP.
REQ-009 In CAP, ReadMem SHALL be written into READ slot i.
REQ-010 After CAP: if i = N-1 the block SHALL go to DONE; otherwise i SHALL increment and the block SHALL go to REQ.
REQ-011 Latency: a single read SHALL assert HANDSHAKE on the 4th rising edge after the request edge (3 cycles per word). A burst of N words SHALL take 3N+1 edges.
REQ-012 In DONE, HANDSHAKE SHALL be 1 and READ SHALL hold. The block SHALL remain in DONE while ENABLE=1 and go to IDLE on the first edge with ENABLE=0.
REQ-013 HANDSHAKE SHALL be 0 in all states except DONE.
REQ-014 READ SHALL hold its last value in IDLE until the next transaction start.
REQ-015 Deasserting ENABLE mid-transaction SHALL NOT abort it.
REQ-016 Unused READ slots SHALL be 0.
REQ-017 AddressMem SHALL hold its last value outside REQ.

Reset
REQ-018 When RESET=0 at a rising edge, the block SHALL set: state IDLE, AddressMem=0, HANDSHAKE=0, READ=0, i=0, latched fields=0.
REQ-019 Reset SHALL override any in-flight transaction; no partial result or handshake SHALL follow.
REQ-020 Reset SHALL take priority over ENABLE on the same edge.

Configuration
REQ-021 Macro MEMCTRL_ADDR_MASK_EN:
- Defined: AddressMem SHALL be masked to bits [3:0] (upper 28 bits 0), so addresses wrap in a 16-word memory.
- Undefined: the full 32-bit address per REQ-007 SHALL be driven.

Verification
Bench: registered 16x16 memory, mem[k]=k except mem[0]=16'hFFFF, mem[2]=16'h0001.
REQ-022 Single read, mem[2]: RESET high, ENABLE=1, Ctrl=10, ADDRESS=2; ADDRESS→X two cycles later. Required: READ=48'h000000000001 with HANDSHAKE=1 by edge 4, held until ENABLE=0.
REQ-023 Horizontal burst: Ctrl=11, IndexCtrl=10, base 4. Required: AddressMem 4,5,6; READ=48'h000600050004; HANDSHAKE on edge 10.
REQ-024 Vertical burst: Ctrl=01, IndexCtrl=10, ADDRESS=48'h0000_0004_0000. Required: AddressMem 0,4,8; READ=48'h00080004FFFF.
REQ-025 Idle/abort cases:
- ENABLE=0 with Ctrl=00 and ADDRESS=48'h00020002: HANDSHAKE stays 0 and AddressMem is unchanged.
- ENABLE dropped mid-burst: burst still completes.
REQ-026 Reset mid-burst: RESET=0 during WAIT. Required: next edge gives IDLE, READ=0, HANDSHAKE=0; no HANDSHAKE afterward.
REQ-027 MEMCTRL_ADDR_MASK_EN defined, Ctrl=11, base 16'h0013, IndexCtrl=01. Required: AddressMem 3,4.

Source files
------------

// File: rtl/memory_controller.sv
// Multi-word read controller for a registered 16-bit memory: single reads plus strided and unit-stride bursts.
// Optional MEMCTRL_ADDR_MASK_EN limits AddressMem to a 16-word space (bits [3:0]).
module memory_controller (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ENABLE,
  input  logic [1:0]  Ctrl,
  input  logic [1:0]  IndexCtrl,
  input  logic [47:0] ADDRESS,
  input  logic [15:0] ReadMem,
  output logic [31:0] AddressMem,
  output logic        HANDSHAKE,
  output logic [47:0] READ
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_CAP,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_ctrl;
  logic [1:0]  r_idx;
  logic [15:0] r_base;
  logic [15:0] r_stride;
  logic [1:0]  r_i;
  logic [31:0] r_addr;
  logic [47:0] r_read;

  logic [1:0]  w_nm1;
  logic        w_last;
  logic [31:0] w_step;
  logic [31:0] w_addr_full;
  logic [31:0] w_addr;
  logic        w_unused;

  // Last word index: single reads are one word; IndexCtrl 11 saturates at three words.
  always_comb begin
    w_nm1 = 2'd0;
    if (r_ctrl != 2'b10) begin
      case (r_idx)
        2'b00:   w_nm1 = 2'd0;
        2'b01:   w_nm1 = 2'd1;
        default: w_nm1 = 2'd2;
      endcase
    end
  end

  assign w_last = (r_i == w_nm1);

  always_comb begin
    w_step = '0;
    case (r_ctrl)
      2'b01:   w_step = {16'd0, r_stride};
      2'b11:   w_step = 32'd1;
      default: w_step = '0;
    endcase
  end

  assign w_addr_full = {16'd0, r_base} + ({30'd0, r_i} * w_step);

`ifdef MEMCTRL_ADDR_MASK_EN
  assign w_addr   = {28'd0, w_addr_full[3:0]};
  assign w_unused = &{1'b0, ADDRESS[47:32], w_addr_full[31:4]};
`else
  assign w_addr   = w_addr_full;
  assign w_unused = &{1'b0, ADDRESS[47:32]};
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (ENABLE && (Ctrl != 2'b00)) w_next = S_REQ;
      S_REQ:   w_next = S_WAIT;
      S_WAIT:  w_next = S_CAP;
      S_CAP:   w_next = w_last ? S_DONE : S_REQ;
      S_DONE:  if (!ENABLE) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state  <= S_IDLE;
      r_ctrl   <= '0;
      r_idx    <= '0;
      r_base   <= '0;
      r_stride <= '0;
      r_i      <= '0;
      r_addr   <= '0;
      r_read   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_next == S_REQ) begin
            r_ctrl   <= Ctrl;
            r_idx    <= IndexCtrl;
            r_base   <= ADDRESS[15:0];
            r_stride <= ADDRESS[31:16];
            r_read   <= '0;
            r_i      <= '0;
          end
        end
        S_REQ: r_addr <= w_addr;
        S_CAP: begin
          r_read[16*r_i +: 16] <= ReadMem;
          if (!w_last) r_i <= r_i + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign AddressMem = r_addr;
  assign HANDSHAKE  = (r_state == S_DONE);
  assign READ       = r_read;

endmodule

// File: tb/tb_memory_controller.sv
// Directed bench for memory_controller against a registered 16x16 memory model.
module tb_memory_controller;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        ENABLE;
  logic [1:0]  Ctrl;
  logic [1:0]  IndexCtrl;
  logic [47:0] ADDRESS;
  logic [15:0] ReadMem;
  logic [31:0] AddressMem;
  logic        HANDSHAKE;
  logic [47:0] READ;

  logic [15:0] mem [16];
  int checks = 0;
  int errors = 0;
  logic unused_tb;

  memory_controller dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .Ctrl(Ctrl), .IndexCtrl(IndexCtrl),
    .ADDRESS(ADDRESS), .ReadMem(ReadMem), .AddressMem(AddressMem),
    .HANDSHAKE(HANDSHAKE), .READ(READ)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) ReadMem <= mem[AddressMem[3:0]];
  assign unused_tb = ^AddressMem[31:4];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one burst of n words (3n+1 edges) from IDLE, checking address issue, handshake timing and result.
  task automatic burst(input string tag, input logic [1:0] c, input logic [1:0] ic,
                       input logic [47:0] addr, input int n,
                       input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                       input logic [47:0] exp_read, input bit drop);
    logic [31:0] exp_a [3];
    exp_a[0] = a0; exp_a[1] = a1; exp_a[2] = a2;
    ENABLE = 1'b1; Ctrl = c; IndexCtrl = ic; ADDRESS = addr;
    for (int e = 1; e <= 3*n + 1; e++) begin
      tick();
      if (e == 1) begin
        chk({tag, "_read_cleared"}, {16'd0, READ}, 64'd0);
        ADDRESS = 'x; Ctrl = 'x;
        if (drop) ENABLE = 1'b0;
      end
      if ((e % 3) == 2) chk({tag, "_addr"}, {32'd0, AddressMem}, {32'd0, exp_a[e/3]});
      chk({tag, "_hs"}, {63'd0, HANDSHAKE}, {63'd0, (e == 3*n + 1)});
    end
    chk({tag, "_read"}, {16'd0, READ}, {16'd0, exp_read});
    if (!drop) begin
      tick();
      chk({tag, "_hs_hold"}, {63'd0, HANDSHAKE}, 64'd1);
      chk({tag, "_read_hold"}, {16'd0, READ}, {16'd0, exp_read});
    end
    ENABLE = 1'b0; Ctrl = 2'b00; ADDRESS = '0;
    tick();
    chk({tag, "_hs_idle"}, {63'd0, HANDSHAKE}, 64'd0);
    chk({tag, "_read_idle"}, {16'd0, READ}, {16'd0, exp_read});
  endtask

  initial begin
    for (int k = 0; k < 16; k++) mem[k] = 16'(k);
    mem[0] = 16'hFFFF;
    mem[2] = 16'h0001;

    RESET = 1'b0; ENABLE = 1'b0; Ctrl = 2'b00; IndexCtrl = 2'b00; ADDRESS = '0;
    tick(); tick();
    chk("rst_addr", {32'd0, AddressMem}, 64'd0);
    chk("rst_hs", {63'd0, HANDSHAKE}, 64'd0);
    chk("rst_read", {16'd0, READ}, 64'd0);
    RESET = 1'b1;
    tick();

    ENABLE = 1'b0; Ctrl = 2'b00; ADDRESS = 48'h0000_0002_0002;
    tick(); tick(); tick();
    chk("idle_hs", {63'd0, HANDSHAKE}, 64'd0);
    chk("idle_addr", {32'd0, AddressMem}, 64'd0);
    ENABLE = 1'b1; Ctrl = 2'b00;
    tick(); tick();
    chk("ctrl00_hs", {63'd0, HANDSHAKE}, 64'd0);
    chk("ctrl00_addr", {32'd0, AddressMem}, 64'd0);
    ENABLE = 1'b0;
    tick();

    // Single read of mem[2]; ADDRESS goes X after the address is issued.
    ENABLE = 1'b1; Ctrl = 2'b10; IndexCtrl = 2'b00; ADDRESS = 48'd2;
    tick();
    chk("single_e1_hs", {63'd0, HANDSHAKE}, 64'd0);
    tick();
    chk("single_e2_addr", {32'd0, AddressMem}, 64'd2);
    chk("single_e2_hs", {63'd0, HANDSHAKE}, 64'd0);
    ADDRESS = 'x; Ctrl = 'x;
    tick();
    chk("single_e3_hs", {63'd0, HANDSHAKE}, 64'd0);
    tick();
    chk("single_e4_hs", {63'd0, HANDSHAKE}, 64'd1);
    chk("single_e4_read", {16'd0, READ}, 64'h0000_0000_0000_0001);
    tick(); tick();
    chk("single_hold_hs", {63'd0, HANDSHAKE}, 64'd1);
    chk("single_hold_read", {16'd0, READ}, 64'h0000_0000_0000_0001);
    ENABLE = 1'b0; Ctrl = 2'b00; ADDRESS = '0;
    tick();
    chk("single_idle_hs", {63'd0, HANDSHAKE}, 64'd0);
    chk("single_idle_read", {16'd0, READ}, 64'h0000_0000_0000_0001);
    chk("single_idle_addr", {32'd0, AddressMem}, 64'd2);

    burst("horiz", 2'b11, 2'b10, 48'd4, 3, 32'd4, 32'd5, 32'd6, 48'h0006_0005_0004, 1'b0);
    burst("vert", 2'b01, 2'b10, 48'h0000_0004_0000, 3, 32'd0, 32'd4, 32'd8,
          48'h0008_0004_FFFF, 1'b0);
    burst("vert_idx3", 2'b01, 2'b11, 48'h0000_0003_0001, 3, 32'd1, 32'd4, 32'd7,
          48'h0007_0004_0001, 1'b0);
    burst("drop", 2'b11, 2'b01, 48'd6, 2, 32'd6, 32'd7, 32'd0, 48'h0000_0007_0006, 1'b1);
    burst("one_word", 2'b11, 2'b00, 48'd9, 1, 32'd9, 32'd0, 32'd0, 48'h0000_0000_0009, 1'b0);
`ifdef MEMCTRL_ADDR_MASK_EN
    burst("mask", 2'b11, 2'b01, 48'h0000_0000_0013, 2, 32'd3, 32'd4, 32'd0,
          48'h0000_0004_0003, 1'b0);
`else
    burst("nomask", 2'b11, 2'b01, 48'h0000_0000_0013, 2, 32'h13, 32'h14, 32'd0,
          48'h0000_0004_0003, 1'b0);
`endif

    // Reset lands during WAIT, with ENABLE still requesting a read.
    ENABLE = 1'b1; Ctrl = 2'b11; IndexCtrl = 2'b10; ADDRESS = 48'd4;
    tick(); tick();
    chk("rstmid_addr_pre", {32'd0, AddressMem}, 64'd4);
    RESET = 1'b0; Ctrl = 2'b10;
    tick();
    chk("rstmid_hs", {63'd0, HANDSHAKE}, 64'd0);
    chk("rstmid_read", {16'd0, READ}, 64'd0);
    chk("rstmid_addr", {32'd0, AddressMem}, 64'd0);
    RESET = 1'b1; ENABLE = 1'b0; Ctrl = 2'b00; ADDRESS = '0;
    for (int e = 0; e < 12; e++) begin
      tick();
      chk("rstmid_no_hs", {63'd0, HANDSHAKE}, 64'd0);
    end
    chk("rstmid_read_after", {16'd0, READ}, 64'd0);
    chk("rstmid_addr_after", {32'd0, AddressMem}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
